// File: rtl/conv3x3_stream_engine.sv
// conv3x3_stream_engine: streams 3-row image columns into a 3x3 window and produces one
// signed output per window position via a sequential 9-tap MAC, bias, shift, ReLU and saturation.
module conv3x3_stream_engine #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 20,
   parameter int IMG_W  = 28,
   parameter int ADDR_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [1:0]          stride,
   input  logic [4:0]          shift_amt,
   input  logic                relu_en,
   input  logic [2*DATA_W-1:0] bias,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic                col_valid,
   output logic                col_ready,
   input  logic [DATA_W-1:0]   in_l1,
   input  logic [DATA_W-1:0]   in_l2,
   input  logic [DATA_W-1:0]   in_l3,
   output logic [3:0]          kernel_addr,
   input  logic [DATA_W-1:0]   kernel_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic [ADDR_W-1:0]   out_addr,
   output logic                busy,
   output logic                done
);
   localparam int IW = $clog2(IMG_W);
   localparam logic [IW-1:0] LAST1 = IW'(IMG_W - 3);
   localparam logic [IW-1:0] LAST2 = IW'((IMG_W - 3) / 2);
   localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

   typedef enum logic [2:0] {IDLE, FILL, MAC, ROUND, OUT, SKIP, DONE} state_t;

   state_t                   state_q, state_d;
   logic [1:0]               cnt_q, cnt_d;
   logic [3:0]               tap_q, tap_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [DATA_W-1:0]        win_q [9];
   logic [DATA_W-1:0]        win_d [9];
   logic                     stride2_q, stride2_d;
   logic [4:0]               shift_q, shift_d;
   logic                     relu_q, relu_d;
   logic [2*DATA_W-1:0]      bias_q, bias_d;
   logic [ADDR_W-1:0]        base_q, base_d;
   logic                     out_valid_q, out_valid_d;
   logic [DATA_W-1:0]        out_data_q, out_data_d;
   logic [ADDR_W-1:0]        out_addr_q, out_addr_d;

   logic signed [ACC_W-1:0]  bias_ext, pix_x, k_x, prod, r_sh, r_rl;
   logic [DATA_W-1:0]        sat;

   // Window is stored row-major (k = row*3 + col) so the tap index addresses it directly
   assign bias_ext = {{(ACC_W - 2*DATA_W){bias_q[2*DATA_W-1]}}, bias_q};
   assign pix_x    = {{(ACC_W - DATA_W){1'b0}}, win_q[tap_q]};
   assign k_x      = {{(ACC_W - DATA_W){kernel_in[DATA_W-1]}}, kernel_in};
   assign prod     = pix_x * k_x;
   assign r_sh     = acc_q >>> shift_q;
   assign r_rl     = (relu_q && r_sh[ACC_W-1]) ? '0 : r_sh;
   assign sat      = (r_rl > SMAX) ? SMAX[DATA_W-1:0] : (r_rl < SMIN) ? SMIN[DATA_W-1:0] : r_rl[DATA_W-1:0];

   assign col_ready   = (state_q == FILL) || (state_q == SKIP);
   assign kernel_addr = tap_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_addr    = out_addr_q;
   assign busy        = (state_q != IDLE) && (state_q != DONE);
   assign done        = state_q == DONE;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tap_d       = tap_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      win_d       = win_q;
      stride2_d   = stride2_q;
      shift_d     = shift_q;
      relu_d      = relu_q;
      bias_d      = bias_q;
      base_d      = base_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      if (col_ready && col_valid) begin
         for (int r = 0; r < 3; r++) begin
            win_d[3*r]   = win_q[3*r+1];
            win_d[3*r+1] = win_q[3*r+2];
         end
         win_d[2] = in_l1;
         win_d[5] = in_l2;
         win_d[8] = in_l3;
      end
      unique case (state_q)
         IDLE: if (start) begin
            stride2_d = stride == 2'd2;
            shift_d   = shift_amt;
            relu_d    = relu_en;
            bias_d    = bias;
            base_d    = base_addr;
            idx_d     = '0;
            cnt_d     = '0;
            state_d   = FILL;
         end
         FILL: if (col_valid) begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd2) begin
               cnt_d   = '0;
               tap_d   = '0;
               acc_d   = bias_ext;
               state_d = MAC;
            end
         end
         MAC: begin
            acc_d   = acc_q + prod;
            tap_d   = (tap_q == 4'd8) ? '0 : tap_q + 4'd1;
            state_d = (tap_q == 4'd8) ? ROUND : MAC;
         end
         ROUND: begin
            out_valid_d = 1'b1;
            out_data_d  = sat;
            out_addr_d  = base_q + ADDR_W'(idx_q);
            state_d     = OUT;
         end
         OUT: if (out_ready) begin
            out_valid_d = 1'b0;
            idx_d       = idx_q + IW'(1);
            state_d     = (idx_q == (stride2_q ? LAST2 : LAST1)) ? DONE : SKIP;
         end
         SKIP: if (col_valid) begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == {1'b0, stride2_q}) begin
               cnt_d   = '0;
               acc_d   = bias_ext;
               state_d = MAC;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         tap_q       <= '0;
         idx_q       <= '0;
         acc_q       <= '0;
         win_q       <= '{default: '0};
         stride2_q   <= 1'b0;
         shift_q     <= '0;
         relu_q      <= 1'b0;
         bias_q      <= '0;
         base_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tap_q       <= tap_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         win_q       <= win_d;
         stride2_q   <= stride2_d;
         shift_q     <= shift_d;
         relu_q      <= relu_d;
         bias_q      <= bias_d;
         base_q      <= base_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
      end
   end
endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// tb_conv3x3_stream_engine: directed strips on an 8-column image with hand-computed results.
module tb_conv3x3_stream_engine;
   logic       clk = 1'b0;
   logic       rst, start, col_valid, col_ready, relu_en, out_valid, out_ready, busy, done;
   logic [1:0] stride;
   logic [4:0] shift_amt;
   logic [15:0] bias;
   logic [7:0] base_addr, in_l1, in_l2, in_l3, kernel_in, out_data, out_addr;
   logic [3:0] kernel_addr;
   logic [7:0] kw [9];
   int         checks = 0, failures = 0, col_n = 0;
   int         pr [3];
   int         exp_v [8];
   bit         ramp = 1'b0;

   conv3x3_stream_engine #(.DATA_W(8), .ACC_W(20), .IMG_W(8), .ADDR_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .stride(stride), .shift_amt(shift_amt),
      .relu_en(relu_en), .bias(bias), .base_addr(base_addr), .col_valid(col_valid),
      .col_ready(col_ready), .in_l1(in_l1), .in_l2(in_l2), .in_l3(in_l3),
      .kernel_addr(kernel_addr), .kernel_in(kernel_in), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Column c (0-based) carries row base plus c+1 in ramp mode
   assign in_l1     = 8'(pr[0] + (ramp ? col_n + 1 : 0));
   assign in_l2     = 8'(pr[1] + (ramp ? col_n + 1 : 0));
   assign in_l3     = 8'(pr[2] + (ramp ? col_n + 1 : 0));
   assign kernel_in = (kernel_addr < 4'd9) ? kw[kernel_addr] : '0;

   task automatic chk(input string tag, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, want);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_col_ready"}, int'(col_ready), 0);
      chk({tag, "_kernel_addr"}, int'(kernel_addr), 0);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_out_data"}, int'(out_data), 0);
      chk({tag, "_out_addr"}, int'(out_addr), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
   endtask

   task automatic set_px(input int p0, input int p1, input int p2, input bit rmp);
      pr[0] = p0;
      pr[1] = p1;
      pr[2] = p2;
      ramp  = rmp;
   endtask

   task automatic set_w(input int w, input int step);
      for (int i = 0; i < 9; i++) kw[i] = 8'(w + step * i);
   endtask

   task automatic set_exp(input int v0, input int step);
      for (int i = 0; i < 8; i++) exp_v[i] = v0 + step * i;
   endtask

   task automatic run(input int s, input int sh, input int rl, input int b, input int base,
                      input int n_exp, input int cols_exp,
                      input bit bp, input bit abort, input bit glitch, input bit stall);
      int outs = 0, dones = 0, hold = 0, cyc = 0, first_v = 0, done_cyc = 0, extra_rdy = 0, ab = 0;
      bit hs_col = 1'b0, hs_out = 1'b0, fin = 1'b0;
      logic [7:0] hd = '0, ha = '0;
      stride    = 2'(s);
      shift_amt = 5'(sh);
      relu_en   = rl[0];
      bias      = 16'(b);
      base_addr = 8'(base);
      col_n     = 0;
      col_valid = 1'b1;
      out_ready = 1'b1;
      start     = 1'b1;
      while (!fin && cyc < 400) begin
         @(negedge clk);
         cyc++;
         start = glitch && cyc == 20;
         if (start) base_addr = 8'h77;
         if (cyc == 1) chk("busy_after_start", int'(busy), 1);
         if (hs_col) col_n++;
         if (hs_out) begin
            outs++;
            if (outs == n_exp) begin
               chk("done_pulse", int'(done), 1);
               chk("busy_fall", int'(busy), 0);
            end
         end
         if (done) begin
            dones++;
            done_cyc = cyc;
         end
         if (dones > 0 && cyc >= done_cyc + 4) fin = 1'b1;
         out_ready = !(bp && outs == 1 && hold < 5);
         if (out_valid && !out_ready) begin
            if (hold == 0) begin
               hd = out_data;
               ha = out_addr;
            end else begin
               chk("bp_data_stable", int'(out_data), int'(hd));
               chk("bp_addr_stable", int'(out_addr), int'(ha));
            end
            chk("bp_col_ready", int'(col_ready), 0);
            hold++;
         end
         if (out_valid && out_ready) begin
            if (outs < n_exp) begin
               chk($sformatf("data%0d", outs), int'($signed(out_data)), exp_v[outs]);
               chk($sformatf("addr%0d", outs), int'(out_addr), (base + outs) % 256);
            end else chk("extra_output", outs, n_exp - 1);
         end
         if (out_valid && first_v == 0) first_v = cyc;
         col_valid = !(stall && cyc % 4 == 1);
         if (col_ready && col_n >= cols_exp) extra_rdy++;
         hs_col = col_valid && col_ready;
         hs_out = out_valid && out_ready;
         if (abort && outs == 2) begin
            ab++;
            if (ab == 4) begin
               chk("abort_in_mac", int'(kernel_addr), 2);
               rst = 1'b1;
               @(negedge clk);
               chk_reset("abort");
               rst = 1'b0;
               fin = 1'b1;
            end
         end
      end
      start = 1'b0;
      if (!fin) chk("timeout", 0, 1);
      else if (!abort) begin
         chk("outputs", outs, n_exp);
         chk("done_count", dones, 1);
         chk("columns", col_n, cols_exp);
         chk("extra_col_ready", extra_rdy, 0);
         if (bp) chk("bp_hold", hold, 5);
         if (!stall) chk("first_valid_cycle", first_v, 14);
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      col_valid = 1'b0;
      out_ready = 1'b0;
      stride = '0;
      shift_amt = '0;
      relu_en = 1'b0;
      bias = '0;
      base_addr = '0;
      set_px(0, 0, 0, 1'b0);
      set_w(0, 0);
      repeat (2) @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;
      @(negedge clk);
      // Unity, stride 1, with a start pulse while busy that must be ignored
      set_px(1, 1, 1, 1'b0);
      set_w(1, 0);
      set_exp(9, 0);
      run(1, 0, 0, 0, 'h10, 6, 8, 1'b0, 1'b0, 1'b1, 1'b0);
      run(2, 0, 0, 0, 'h10, 3, 7, 1'b0, 1'b0, 1'b0, 1'b0);
      // 9*10*2 - 100 = 80, >>> 2 = 20
      set_px(10, 10, 10, 1'b0);
      set_w(2, 0);
      set_exp(20, 0);
      run(0, 2, 0, -100, 'h40, 6, 8, 1'b0, 1'b0, 1'b0, 1'b0);
      set_px(255, 255, 255, 1'b0);
      set_w(127, 0);
      set_exp(127, 0);
      run(2, 0, 0, 0, 0, 3, 7, 1'b0, 1'b0, 1'b0, 1'b0);
      set_w(-128, 0);
      set_exp(-128, 0);
      run(2, 0, 0, 0, 0, 3, 7, 1'b0, 1'b0, 1'b0, 1'b0);
      set_exp(0, 0);
      run(2, 0, 1, 0, 0, 3, 7, 1'b0, 1'b0, 1'b0, 1'b0);
      // Backpressure on output 1; base 0xFE also exercises address wrap
      set_px(1, 1, 1, 1'b0);
      set_w(1, 0);
      set_exp(9, 0);
      run(1, 0, 0, 0, 'hFE, 6, 8, 1'b1, 1'b0, 1'b0, 1'b0);
      // Ramp columns: stride 1 gives 3*(3i+6), stride 2 with input stalls gives 3*(6i+6)
      set_px(0, 0, 0, 1'b1);
      set_exp(18, 9);
      run(3, 0, 0, 0, 'h20, 6, 8, 1'b0, 1'b0, 1'b0, 1'b0);
      set_exp(18, 18);
      run(2, 0, 0, 0, 'h30, 3, 7, 1'b0, 1'b0, 1'b0, 1'b1);
      // Rows 1,2,3 with weight k: 1*3 + 2*12 + 3*21 = 90
      set_px(1, 2, 3, 1'b0);
      set_w(0, 1);
      set_exp(90, 0);
      run(2, 0, 0, 0, 'h50, 3, 7, 1'b0, 1'b0, 1'b0, 1'b0);
      // Reset during MAC of output 2, then a fresh strip must reproduce the unity results
      set_px(1, 1, 1, 1'b0);
      set_w(1, 0);
      set_exp(9, 0);
      run(1, 0, 0, 0, 'h10, 6, 8, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      run(1, 0, 0, 0, 'h10, 6, 8, 1'b0, 1'b0, 1'b0, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
